// File: rtl/rtob_run_ctrl.sv
// Run-time sequencer for a bank of RTOB output cores: owns the shared
// 64-bit timeline, drives the common auto_start/flush lines, decodes host
// commands and latches per-channel error strobes into sticky vectors.
module rtob_run_ctrl #(
    parameter int NUM_CH       = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [63:0]       cmd_data,
    input  logic              halt_on_err,
    input  logic [NUM_CH-1:0] ch_empty,
    input  logic [NUM_CH-1:0] ch_ts_err,
    input  logic [NUM_CH-1:0] ch_ovf_err,
    output logic [63:0]       counter,
    output logic              auto_start,
    output logic              flush,
    output logic [2:0]        state,
    output logic [NUM_CH-1:0] ts_err_sticky,
    output logic [NUM_CH-1:0] ovf_err_sticky,
    output logic              drained,
    output logic              bad_cmd
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_HALT  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ARM   = 3'd1;
    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_STOP  = 3'd3;
    localparam logic [2:0] OP_FLUSH = 3'd4;
    localparam logic [2:0] OP_CLR   = 3'd5;

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    state_t              state_q, state_d;
    logic [63:0]         counter_q, counter_d;
    logic [7:0]          fl_cnt_q, fl_cnt_d;
    logic                cmd_ready_q, auto_start_q, flush_q, drained_q, bad_cmd_q;
    logic [NUM_CH-1:0]   ts_sticky_q, ts_sticky_d;
    logic [NUM_CH-1:0]   ovf_sticky_q, ovf_sticky_d;
    logic                accept_s, err_s, bad_s, clr_s;

    // Command decode, next-state, timeline and sticky-error next values.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        fl_cnt_d  = fl_cnt_q;
        bad_s     = 1'b0;
        accept_s  = cmd_valid & cmd_ready_q;
        err_s     = |(ch_ts_err | ch_ovf_err);
        clr_s     = accept_s && (cmd_op == OP_CLR);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_NOP, OP_CLR: state_d = state_q;
                        OP_ARM: begin
                            state_d   = ST_ARMED;
                            counter_d = cmd_data;
                        end
                        OP_FLUSH: begin
                            state_d   = ST_FLUSH;
                            counter_d = 64'd0;
                            fl_cnt_d  = 8'd0;
                        end
                        default: bad_s = 1'b1;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARMED: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_NOP, OP_CLR: state_d = state_q;
                        OP_ARM:   counter_d = cmd_data;
                        OP_START: state_d = ST_RUN;
                        OP_STOP:  state_d = ST_IDLE;
                        OP_FLUSH: begin
                            state_d   = ST_FLUSH;
                            counter_d = 64'd0;
                            fl_cnt_d  = 8'd0;
                        end
                        default: bad_s = 1'b1;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (halt_on_err && err_s) begin
                    // Error halt wins over any command; the timeline freezes.
                    state_d = ST_HALT;
                    if (accept_s) begin
                        case (cmd_op)
                            OP_NOP, OP_CLR, OP_STOP: bad_s = 1'b0;
                            default:                 bad_s = 1'b1;
                        endcase
                    end else begin
                        bad_s = 1'b0;
                    end
                end else begin
                    counter_d = counter_q + 64'd1;
                    if (accept_s) begin
                        case (cmd_op)
                            OP_NOP, OP_CLR: state_d = state_q;
                            OP_STOP: begin
                                state_d   = ST_HALT;
                                counter_d = counter_q;
                            end
                            OP_FLUSH: begin
                                state_d   = ST_FLUSH;
                                counter_d = 64'd0;
                                fl_cnt_d  = 8'd0;
                            end
                            default: bad_s = 1'b1;
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            ST_HALT: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_NOP, OP_CLR, OP_STOP: state_d = state_q;
                        OP_START: state_d = ST_RUN;
                        OP_ARM: begin
                            state_d   = ST_ARMED;
                            counter_d = cmd_data;
                        end
                        OP_FLUSH: begin
                            state_d   = ST_FLUSH;
                            counter_d = 64'd0;
                            fl_cnt_d  = 8'd0;
                        end
                        default: bad_s = 1'b1;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_FLUSH: begin
                counter_d = 64'd0;
                if (fl_cnt_q == FLUSH_LAST) begin
                    state_d  = ST_IDLE;
                    fl_cnt_d = 8'd0;
                end else begin
                    fl_cnt_d = fl_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = 64'd0;
                fl_cnt_d  = 8'd0;
            end
        endcase

        // Set beats clear on the same edge; strobes are ignored while flushing.
        if (state_q == ST_FLUSH) begin
            ts_sticky_d  = ts_sticky_q;
            ovf_sticky_d = ovf_sticky_q;
        end else begin
            ts_sticky_d  = (clr_s ? {NUM_CH{1'b0}} : ts_sticky_q)  | ch_ts_err;
            ovf_sticky_d = (clr_s ? {NUM_CH{1'b0}} : ovf_sticky_q) | ch_ovf_err;
        end
    end

    // State, timeline and registered copies of every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            counter_q    <= 64'd0;
            fl_cnt_q     <= 8'd0;
            cmd_ready_q  <= 1'b1;
            auto_start_q <= 1'b0;
            flush_q      <= 1'b0;
            ts_sticky_q  <= {NUM_CH{1'b0}};
            ovf_sticky_q <= {NUM_CH{1'b0}};
            drained_q    <= 1'b0;
            bad_cmd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            fl_cnt_q     <= fl_cnt_d;
            cmd_ready_q  <= (state_d != ST_FLUSH);
            auto_start_q <= (state_d == ST_RUN);
            flush_q      <= (state_d == ST_FLUSH);
            ts_sticky_q  <= ts_sticky_d;
            ovf_sticky_q <= ovf_sticky_d;
            drained_q    <= &ch_empty;
            bad_cmd_q    <= bad_s;
        end
    end

    assign state          = state_q;
    assign counter        = counter_q;
    assign cmd_ready      = cmd_ready_q;
    assign auto_start     = auto_start_q;
    assign flush          = flush_q;
    assign ts_err_sticky  = ts_sticky_q;
    assign ovf_err_sticky = ovf_sticky_q;
    assign drained        = drained_q;
    assign bad_cmd        = bad_cmd_q;

endmodule

// File: tb/tb_rtob_run_ctrl.sv
// Directed bench for rtob_run_ctrl: scenario tasks with hand-computed values.
module tb_rtob_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        halt_on_err = 1'b0;
    logic [7:0]  ch_empty = 8'h00;
    logic [7:0]  ch_ts_err = 8'h00;
    logic [7:0]  ch_ovf_err = 8'h00;
    logic [63:0] counter;
    logic        auto_start, flush, drained, bad_cmd;
    logic [2:0]  state;
    logic [7:0]  ts_err_sticky, ovf_err_sticky;

    int total = 0;
    int bad = 0;

    rtob_run_ctrl #(.NUM_CH(8), .FLUSH_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .halt_on_err(halt_on_err), .ch_empty(ch_empty), .ch_ts_err(ch_ts_err), .ch_ovf_err(ch_ovf_err),
        .counter(counter), .auto_start(auto_start), .flush(flush), .state(state),
        .ts_err_sticky(ts_err_sticky), .ovf_err_sticky(ovf_err_sticky),
        .drained(drained), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    // One command for one edge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [63:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 64'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (counter !== 64'd0) begin bad++; $display("FAIL reset_counter got=%h exp=0", counter); end
        total++; if ({auto_start, flush, bad_cmd, drained} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {auto_start, flush, bad_cmd, drained}); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        total++; if ({ts_err_sticky, ovf_err_sticky} !== 16'h0000) begin bad++; $display("FAIL reset_sticky got=%h exp=0000", {ts_err_sticky, ovf_err_sticky}); end
    endtask

    task automatic test_arm_start;
        send(3'd1, 64'h100);
        total++; if (state !== 3'd1 || counter !== 64'h100) begin bad++; $display("FAIL arm got=%0d/%h exp=1/100", state, counter); end
        total++; if (auto_start !== 1'b0) begin bad++; $display("FAIL arm_autostart got=%b exp=0", auto_start); end
        send(3'd2, 64'd0);
        total++; if (counter !== 64'h100 || auto_start !== 1'b1 || state !== 3'd2) begin bad++; $display("FAIL start0 got=%h/%b/%0d exp=100/1/2", counter, auto_start, state); end
        @(negedge clk);
        total++; if (counter !== 64'h101) begin bad++; $display("FAIL start1 got=%h exp=101", counter); end
        @(negedge clk);
        total++; if (counter !== 64'h102) begin bad++; $display("FAIL start2 got=%h exp=102", counter); end
    endtask

    task automatic test_err_halt;
        halt_on_err = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (counter !== 64'h105) begin bad++; $display("FAIL pre_halt got=%h exp=105", counter); end
        ch_ts_err = 8'h08;
        @(negedge clk);
        ch_ts_err = 8'h00;
        total++; if (state !== 3'd3 || counter !== 64'h105) begin bad++; $display("FAIL err_halt got=%0d/%h exp=3/105", state, counter); end
        total++; if (ts_err_sticky !== 8'h08 || auto_start !== 1'b0) begin bad++; $display("FAIL err_sticky got=%h/%b exp=08/0", ts_err_sticky, auto_start); end
        @(negedge clk);
        total++; if (counter !== 64'h105) begin bad++; $display("FAIL halt_frozen got=%h exp=105", counter); end
        send(3'd2, 64'd0);
        total++; if (state !== 3'd2 || counter !== 64'h105) begin bad++; $display("FAIL resume0 got=%0d/%h exp=2/105", state, counter); end
        @(negedge clk);
        total++; if (counter !== 64'h106) begin bad++; $display("FAIL resume1 got=%h exp=106", counter); end
        halt_on_err = 1'b0;
    endtask

    task automatic test_clr_err;
        ch_ovf_err = 8'h01;
        send(3'd5, 64'd0);
        ch_ovf_err = 8'h00;
        total++; if (ovf_err_sticky !== 8'h01 || ts_err_sticky !== 8'h00) begin bad++; $display("FAIL clr_set_wins got=%h/%h exp=01/00", ovf_err_sticky, ts_err_sticky); end
        total++; if (bad_cmd !== 1'b0 || state !== 3'd2) begin bad++; $display("FAIL clr_legal got=%b/%0d exp=0/2", bad_cmd, state); end
    endtask

    task automatic test_wrap;
        send(3'd3, 64'd0);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL stop got=%0d exp=3", state); end
        send(3'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        total++; if (state !== 3'd1 || counter !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL rearm got=%0d/%h exp=1/fffffffffffffffe", state, counter); end
        send(3'd2, 64'd0);
        @(negedge clk);
        total++; if (counter !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wrap_max got=%h exp=ffffffffffffffff", counter); end
        @(negedge clk);
        total++; if (counter !== 64'd0 || state !== 3'd2) begin bad++; $display("FAIL wrap_zero got=%h/%0d exp=0/2", counter, state); end
        @(negedge clk);
        total++; if (counter !== 64'd1) begin bad++; $display("FAIL wrap_one got=%h exp=1", counter); end
    endtask

    task automatic test_flush;
        send(3'd5, 64'd0);
        total++; if (ovf_err_sticky !== 8'h00) begin bad++; $display("FAIL clr_plain got=%h exp=00", ovf_err_sticky); end
        send(3'd4, 64'd0);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 64'h55;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            ch_ovf_err = (i == 1) ? 8'hFF : 8'h00;
            total++; if (flush !== 1'b1 || cmd_ready !== 1'b0 || counter !== 64'd0 || state !== 3'd4) begin bad++; $display("FAIL flush_cyc%0d got=%b/%b/%h/%0d exp=1/0/0/4", i, flush, cmd_ready, counter, state); end
        end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 64'd0; ch_ovf_err = 8'h00;
        total++; if (flush !== 1'b0 || state !== 3'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL flush_end got=%b/%0d/%b exp=0/0/1", flush, state, cmd_ready); end
        total++; if (ovf_err_sticky !== 8'h00) begin bad++; $display("FAIL flush_ignores_err got=%h exp=00", ovf_err_sticky); end
    endtask

    task automatic test_bad_cmd;
        send(3'd2, 64'd0);
        total++; if (bad_cmd !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL bad_start got=%b/%0d exp=1/0", bad_cmd, state); end
        @(negedge clk);
        total++; if (bad_cmd !== 1'b0) begin bad++; $display("FAIL bad_pulse got=%b exp=0", bad_cmd); end
        send(3'd7, 64'd0);
        total++; if (bad_cmd !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL bad_op7 got=%b/%0d exp=1/0", bad_cmd, state); end
        send(3'd0, 64'd0);
        total++; if (bad_cmd !== 1'b0) begin bad++; $display("FAIL nop got=%b exp=0", bad_cmd); end
        ch_empty = 8'hFF;
        @(negedge clk);
        total++; if (drained !== 1'b1) begin bad++; $display("FAIL drained got=%b exp=1", drained); end
        ch_empty = 8'hFE;
        @(negedge clk);
        total++; if (drained !== 1'b0) begin bad++; $display("FAIL not_drained got=%b exp=0", drained); end
    endtask

    task automatic test_reset_mid_flush;
        send(3'd4, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (state !== 3'd0 || flush !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_flush got=%0d/%b/%b exp=0/0/1", state, flush, cmd_ready); end
        send(3'd4, 64'd0);
        repeat (3) @(negedge clk);
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL reflush_last got=%b exp=1", flush); end
        @(negedge clk);
        total++; if (flush !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL reflush_end got=%b/%0d exp=0/0", flush, state); end
    endtask

    initial begin
        test_reset;
        test_arm_start;
        test_err_halt;
        test_clr_err;
        test_wrap;
        test_flush;
        test_bad_cmd;
        test_reset_mid_flush;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
